// File: rtl/cart_nav_ctrl_if.sv
// Sensor inputs and drive command between the cart sensing front end and cart_nav_ctrl.
interface cart_nav_ctrl_if;
  logic       enable;
  logic [2:0] track;
  logic [8:0] distance;
  logic       distance_valid;
  logic [2:0] mode;
  logic       obstacle;

  modport master (output enable, track, distance, distance_valid, input mode, obstacle);
  modport slave  (input enable, track, distance, distance_valid, output mode, obstacle);
endinterface

// File: rtl/cart_nav_ctrl.sv
// Navigation decision stage: debounced line tracking, obstacle hysteresis, search/halt/back-off.
// Optional distance watchdog enabled by defining NAV_DIST_WATCHDOG_EN.
module cart_nav_ctrl #(
  parameter int unsigned DEBOUNCE    = 4,
  parameter int unsigned LOST_CYCLES = 5_000_000,
  parameter int unsigned HALT_CYCLES = 10_000_000,
  parameter int unsigned BACK_CYCLES = 30_000_000,
  parameter int unsigned STOP_CM     = 20,
  parameter int unsigned HYST_CM     = 5,
  parameter int unsigned WDT_CYCLES  = 50_000_000
) (
  input logic            clk,
  input logic            rst,
  cart_nav_ctrl_if.slave bus
);

  localparam int unsigned DbW = $clog2(DEBOUNCE + 1);

  localparam logic [2:0] ModeStop  = 3'b000;
  localparam logic [2:0] ModeLeft  = 3'b001;
  localparam logic [2:0] ModeRight = 3'b010;
  localparam logic [2:0] ModeFwd   = 3'b011;
  localparam logic [2:0] ModeBack  = 3'b100;

  typedef enum logic [2:0] {StIdle, StFollow, StSearch, StGiveup, StHalt, StBackoff} state_e;
  typedef enum logic [1:0] {DirFwd, DirLeft, DirRight, DirLost} dir_e;

  function automatic dir_e decode(logic [2:0] t);
    case (t)
      3'b010, 3'b111, 3'b101: decode = DirFwd;
      3'b100, 3'b110:         decode = DirLeft;
      3'b001, 3'b011:         decode = DirRight;
      default:                decode = DirLost;
    endcase
  endfunction

  function automatic logic [2:0] follow_mode(dir_e d);
    case (d)
      DirFwd:   follow_mode = ModeFwd;
      DirLeft:  follow_mode = ModeLeft;
      DirRight: follow_mode = ModeRight;
      default:  follow_mode = ModeStop;
    endcase
  endfunction

  // Sensor conditioning
  logic [2:0]     sync1_q, sync2_q, cand_q, trk_q;
  logic [DbW-1:0] db_cnt_q, db_cnt_d;

  always_comb begin
    db_cnt_d = db_cnt_q;
    if (sync2_q != cand_q) begin
      db_cnt_d = DbW'(1);
    end else if (db_cnt_q < DbW'(DEBOUNCE)) begin
      db_cnt_d = db_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q  <= 3'b000;
      sync2_q  <= 3'b000;
      cand_q   <= 3'b000;
      trk_q    <= 3'b000;
      db_cnt_q <= '0;
    end else begin
      sync1_q  <= bus.track;
      sync2_q  <= sync1_q;
      cand_q   <= sync2_q;
      db_cnt_q <= db_cnt_d;
      if (db_cnt_d >= DbW'(DEBOUNCE)) begin
        trk_q <= sync2_q;
      end
    end
  end

  // Obstacle flag: evaluated the cycle after a distance strobe
  logic [8:0] dist_q;
  logic       dv_q;
  logic       obstacle_q;

`ifdef NAV_DIST_WATCHDOG_EN
  logic [31:0] wdt_q;

  always_ff @(posedge clk) begin
    if (rst || bus.distance_valid) begin
      wdt_q <= '0;
    end else if (wdt_q != 32'hFFFF_FFFF) begin
      wdt_q <= wdt_q + 32'd1;
    end
  end
`else
  logic unused_wdt;
  assign unused_wdt = ^WDT_CYCLES;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      dist_q     <= 9'd511;
      dv_q       <= 1'b0;
      obstacle_q <= 1'b0;
    end else begin
      dv_q <= bus.distance_valid;
      if (bus.distance_valid) begin
        dist_q <= bus.distance;
      end
      if (dv_q) begin
        if (32'(dist_q) < STOP_CM) begin
          obstacle_q <= 1'b1;
        end else if (32'(dist_q) >= STOP_CM + HYST_CM) begin
          obstacle_q <= 1'b0;
        end
`ifdef NAV_DIST_WATCHDOG_EN
      end else if (wdt_q >= WDT_CYCLES) begin
        // No fresh range reading: fail safe until the next strobe re-evaluates
        obstacle_q <= 1'b1;
`endif
      end
    end
  end

  // Navigation FSM
  state_e      state_q;
  logic [2:0]  mode_q;
  logic [31:0] cnt_q, cnt_inc;
  logic        last_right_q;
  dir_e        dir;
  logic [2:0]  steer, search_mode;

  always_comb begin
    dir         = decode(trk_q);
    steer       = follow_mode(dir);
    search_mode = last_right_q ? ModeRight : ModeLeft;
    cnt_inc     = (&cnt_q) ? cnt_q : cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      mode_q       <= ModeStop;
      cnt_q        <= '0;
      last_right_q <= 1'b0;
    end else begin
      if (dir == DirLeft) begin
        last_right_q <= 1'b0;
      end else if (dir == DirRight) begin
        last_right_q <= 1'b1;
      end
      cnt_q <= cnt_inc;
      if (!bus.enable) begin
        state_q <= StIdle;
        mode_q  <= ModeStop;
        cnt_q   <= '0;
      end else if (obstacle_q && (state_q inside {StFollow, StSearch, StGiveup})) begin
        state_q <= StHalt;
        mode_q  <= ModeStop;
        cnt_q   <= '0;
      end else begin
        unique case (state_q)
          StIdle: begin
            state_q <= StFollow;
            mode_q  <= steer;
            cnt_q   <= '0;
          end
          StFollow: begin
            if (dir == DirLost) begin
              state_q <= StSearch;
              mode_q  <= search_mode;
              cnt_q   <= '0;
            end else begin
              mode_q <= steer;
            end
          end
          StSearch: begin
            if (dir != DirLost) begin
              state_q <= StFollow;
              mode_q  <= steer;
              cnt_q   <= '0;
            end else if (cnt_q >= LOST_CYCLES - 1) begin
              state_q <= StGiveup;
              mode_q  <= ModeStop;
              cnt_q   <= '0;
            end else begin
              mode_q <= search_mode;
            end
          end
          StGiveup: begin
            if (dir != DirLost) begin
              state_q <= StFollow;
              mode_q  <= steer;
              cnt_q   <= '0;
            end else begin
              mode_q <= ModeStop;
            end
          end
          StHalt: begin
            if (cnt_q >= HALT_CYCLES - 1) begin
              cnt_q <= '0;
              if (obstacle_q) begin
                state_q <= StBackoff;
                mode_q  <= ModeBack;
              end else begin
                state_q <= StFollow;
                mode_q  <= steer;
              end
            end else begin
              mode_q <= ModeStop;
            end
          end
          StBackoff: begin
            if (cnt_q >= BACK_CYCLES - 1) begin
              state_q <= StFollow;
              mode_q  <= steer;
              cnt_q   <= '0;
            end else begin
              mode_q <= ModeBack;
            end
          end
          default: begin
            state_q <= StIdle;
            mode_q  <= ModeStop;
            cnt_q   <= '0;
          end
        endcase
      end
    end
  end

  assign bus.mode     = mode_q;
  assign bus.obstacle = obstacle_q;

endmodule

// File: tb/tb_cart_nav_ctrl.sv
// Directed scenarios plus randomized stimulus for cart_nav_ctrl, checked every cycle
// against a behavioural model.
module tb_cart_nav_ctrl;

  localparam int unsigned DEBOUNCE = 4;
  localparam int unsigned LOST     = 20;
  localparam int unsigned HALT     = 10;
  localparam int unsigned BACK     = 16;
  localparam int unsigned STOP     = 20;
  localparam int unsigned HYST     = 5;
  localparam int unsigned WDT      = 100;

  localparam int MIdle = 0, MFollow = 1, MSearch = 2, MGiveup = 3, MHalt = 4, MBack = 5;

  logic clk = 1'b0;
  logic rst;
  cart_nav_ctrl_if bus ();

  cart_nav_ctrl #(
    .DEBOUNCE    (DEBOUNCE),
    .LOST_CYCLES (LOST),
    .HALT_CYCLES (HALT),
    .BACK_CYCLES (BACK),
    .STOP_CM     (STOP),
    .HYST_CM     (HYST),
    .WDT_CYCLES  (WDT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  string       phase    = "reset";

  task automatic check_eq(string tag, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s.%s: got %0h expected %0h at %0t", phase, tag, got, exp, $time);
    end
  endtask

  // Directed expectations that only hold when no watchdog is forcing the obstacle flag
  task automatic spot(string tag, logic [31:0] got, logic [31:0] exp);
`ifndef NAV_DIST_WATCHDOG_EN
    check_eq(tag, got, exp);
`endif
  endtask

  // Behavioural model
  logic [2:0] m_s1, m_s2, m_trk, m_mode;
  logic [2:0] m_hist[$];
  bit         m_pend, m_obs, m_right;
  int         m_dist, m_state, m_time, m_wdt;

  function automatic logic [2:0] m_steer(logic [2:0] t);
    if (t inside {3'b010, 3'b111, 3'b101}) return 3'b011;
    if (t inside {3'b100, 3'b110}) return 3'b001;
    if (t inside {3'b001, 3'b011}) return 3'b010;
    return 3'b000;
  endfunction

  task automatic model_step();
    logic [2:0] want;
    int         nxt;
    bit         same;
    if (rst) begin
      m_s1 = 0; m_s2 = 0; m_trk = 0; m_mode = 0; m_hist.delete();
      m_pend = 0; m_obs = 0; m_right = 0; m_dist = 511;
      m_state = MIdle; m_time = 0; m_wdt = 0;
      return;
    end
    want = m_steer(m_trk);
    nxt  = m_state;
    if (!bus.enable) nxt = MIdle;
    else if (m_obs && (m_state inside {MFollow, MSearch, MGiveup})) nxt = MHalt;
    else begin
      case (m_state)
        MIdle:   nxt = MFollow;
        MFollow: if (m_trk == 0) nxt = MSearch;
        MSearch: if (m_trk != 0) nxt = MFollow; else if (m_time == LOST) nxt = MGiveup;
        MGiveup: if (m_trk != 0) nxt = MFollow;
        MHalt:   if (m_time == HALT) nxt = m_obs ? MBack : MFollow;
        MBack:   if (m_time == BACK) nxt = MFollow;
        default: nxt = MIdle;
      endcase
    end
    m_time = (nxt != m_state) ? 1 : m_time + 1;
    case (nxt)
      MFollow: m_mode = want;
      MSearch: m_mode = m_right ? 3'b010 : 3'b001;
      MBack:   m_mode = 3'b100;
      default: m_mode = 3'b000;
    endcase
    m_state = nxt;
    if (want == 3'b001) m_right = 0;
    if (want == 3'b010) m_right = 1;
    // Obstacle flag with hysteresis
    if (m_pend) begin
      if (m_dist < STOP) m_obs = 1;
      else if (m_dist >= STOP + HYST) m_obs = 0;
    end
`ifdef NAV_DIST_WATCHDOG_EN
    else if (m_wdt >= WDT) m_obs = 1;
    m_wdt = bus.distance_valid ? 0 : m_wdt + 1;
`endif
    m_pend = bus.distance_valid;
    if (bus.distance_valid) m_dist = bus.distance;
    // Accept a sample once the last DEBOUNCE synchronized samples agree
    m_hist.push_back(m_s2);
    if (m_hist.size() > DEBOUNCE) void'(m_hist.pop_front());
    if (m_hist.size() == DEBOUNCE) begin
      same = 1;
      foreach (m_hist[i]) if (m_hist[i] != m_s2) same = 0;
      if (same) m_trk = m_s2;
    end
    m_s2 = m_s1;
    m_s1 = bus.track;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_eq("mode", 32'(bus.mode), 32'(m_mode));
    check_eq("obstacle", 32'(bus.obstacle), 32'(m_obs));
  endtask

  task automatic run(int n);
    repeat (n) tick();
  endtask

  task automatic strobe(int d);
    bus.distance       = 9'(d);
    bus.distance_valid = 1'b1;
    tick();
    bus.distance_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.enable = 1'b0; bus.track = 3'b000; bus.distance = 9'd0; bus.distance_valid = 1'b0;
    tick();
    bus.distance = 9'd5; bus.distance_valid = 1'b1;
    tick();
    bus.distance_valid = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    check_eq("rst_mode", 32'(bus.mode), 32'd0);
    check_eq("rst_obstacle", 32'(bus.obstacle), 32'd0);

    phase = "startup";
    bus.enable = 1'b1; bus.track = 3'b010;
    run(12);
    spot("fwd", 32'(bus.mode), 32'd3);

    phase = "follow";
    bus.track = 3'b110; run(10); spot("left_110", 32'(bus.mode), 32'd1);
    bus.track = 3'b100; run(10); spot("left_100", 32'(bus.mode), 32'd1);
    bus.track = 3'b011; run(10); spot("right_011", 32'(bus.mode), 32'd2);
    bus.track = 3'b010; run(10);
    bus.track = 3'b110; run(3);
    bus.track = 3'b010; run(10); spot("glitch", 32'(bus.mode), 32'd3);

    phase = "lost";
    bus.track = 3'b100; run(10);
    bus.track = 3'b000; run(30); spot("giveup", 32'(bus.mode), 32'd0);
    bus.track = 3'b010; run(10); spot("refind", 32'(bus.mode), 32'd3);

    phase = "obstacle";
    strobe(19); run(3);
    spot("set", 32'(bus.obstacle), 32'd1);
    spot("halt", 32'(bus.mode), 32'd0);
    run(12); spot("backoff", 32'(bus.mode), 32'd4);
    strobe(30); run(20);
    spot("resume", 32'(bus.mode), 32'd3);
    strobe(20); run(15);
    spot("eq_stop", 32'(bus.obstacle), 32'd0);
    spot("eq_stop_mode", 32'(bus.mode), 32'd3);
    strobe(19); run(2); spot("hyst_set", 32'(bus.obstacle), 32'd1);
    strobe(24); run(2); spot("hyst_hold", 32'(bus.obstacle), 32'd1);
    strobe(25); run(2); spot("hyst_clear", 32'(bus.obstacle), 32'd0);
    run(40); spot("after_hyst", 32'(bus.mode), 32'd3);

    phase = "abort";
    strobe(10); run(20); spot("in_backoff", 32'(bus.mode), 32'd4);
    bus.enable = 1'b0; tick(); spot("abort_stop", 32'(bus.mode), 32'd0);
    strobe(40); run(3);
    bus.enable = 1'b1; run(3); spot("no_resume", 32'(bus.mode), 32'd3);

`ifdef NAV_DIST_WATCHDOG_EN
    phase = "watchdog";
    run(110);
    check_eq("wdt_force", 32'(bus.obstacle), 32'd1);
    check_eq("wdt_not_fwd", 32'(bus.mode == 3'b011), 32'd0);
    strobe(100); run(2);
    check_eq("wdt_clear", 32'(bus.obstacle), 32'd0);
`endif

    phase = "random";
    for (int i = 0; i < 1500; i++) begin
      int hold;
      bus.track = 3'($urandom_range(0, 7));
      hold = ($urandom_range(0, 9) == 0) ? 40 : int'($urandom_range(1, 14));
      for (int k = 0; k < hold; k++) begin
        if ($urandom_range(0, 9) == 0) begin
          bus.distance = ($urandom_range(0, 3) == 0) ? 9'($urandom_range(0, 511))
                                                     : 9'($urandom_range(10, 35));
          bus.distance_valid = 1'b1;
        end else begin
          bus.distance_valid = 1'b0;
        end
        if (bus.enable) begin
          if ($urandom_range(0, 299) == 0) bus.enable = 1'b0;
        end else if ($urandom_range(0, 19) == 0) begin
          bus.enable = 1'b1;
        end
        rst = ($urandom_range(0, 999) == 0);
        tick();
      end
    end
    rst = 1'b0;
    bus.distance_valid = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cart_nav_ctrl.md
Name: cart_nav_ctrl

Overview:
- Navigation decision stage placed directly upstream of the motor driver.
- Samples three IR line-tracking sensors and an ultrasonic distance reading, then produces the 3-bit drive `mode` consumed by the motor block.
- Handles debounce, line-loss search, obstacle halt and timed back-off.

Parameters:
- DEBOUNCE, 4: consecutive identical synchronized samples required to accept a new sensor value (≥1).
- LOST_CYCLES, 5_000_000: cycles spent searching after line loss before giving up.
- HALT_CYCLES, 10_000_000: cycles held in stop after an obstacle is detected.
- BACK_CYCLES, 30_000_000: cycles driven backward during back-off.
- STOP_CM, 20: obstacle is set when distance < STOP_CM.
- HYST_CM, 5: obstacle clears when distance ≥ STOP_CM+HYST_CM.
- WDT_CYCLES, 50_000_000: distance watchdog timeout; used only with the optional feature.

Ports:
- clk  in  1  system clock, 100 MHz
- rst  in  1  synchronous, active-high reset
- enable  in  1  1 = autonomous driving allowed
- track  in  3  {left,mid,right} IR sensors, 1 = line seen; asynchronous to clk
- distance  in  9  ultrasonic range in cm, 0..511
- distance_valid  in  1  one-cycle strobe; distance is valid this cycle
- mode  out  3  000 stop, 001 turn left, 010 turn right, 011 forward, 100 backward
- obstacle  out  1  registered obstacle flag (with hysteresis)

Behaviour:
- Clock and reset
  - One clock: clk.
  - rst is synchronous and active-high. All state updates on posedge clk; rst is sampled there.
  - Reset values: mode=000, obstacle=0, FSM=IDLE, all counters 0, last_dir=LEFT, debounced track=000, distance latch=511.
- Sensor conditioning
  - Each track bit passes through a 2-FF synchronizer.
  - Debounced vector trk updates only after DEBOUNCE consecutive equal synchronized samples.
  - Worst-case latency from a track edge to trk: 2+DEBOUNCE cycles.
- Obstacle flag
  - Updated only on the cycle after distance_valid.
  - Set if distance < STOP_CM. Cleared if distance ≥ STOP_CM+HYST_CM. Otherwise held.
  - distance=STOP_CM exactly does not set the flag.
- Decode of trk
  - 010, 111, 101 → FWD.
  - 100, 110 → LEFT.
  - 001, 011 → RIGHT.
  - 000 → LOST.
  - last_dir records the most recent LEFT/RIGHT decode.
- FSM states: IDLE, FOLLOW, SEARCH, GIVEUP, HALT, BACKOFF.
- Transition priority (highest first): rst > !enable (→IDLE from any state) > obstacle (→HALT from FOLLOW/SEARCH/GIVEUP) > state-local rules.
- Per-state rules:
  - IDLE: mode=000. enable=1 → FOLLOW.
  - FOLLOW: mode=011/001/010 per decode. LOST → SEARCH; clear the counter.
  - SEARCH: mode = last_dir (001 or 010). trk≠000 → FOLLOW. Counter reaches LOST_CYCLES-1 → GIVEUP.
  - GIVEUP: mode=000. trk≠000 → FOLLOW.
  - HALT: mode=000 for HALT_CYCLES. Then obstacle=1 → BACKOFF, else → FOLLOW. An obstacle rising again during HALT does not restart the count.
  - BACKOFF: mode=100 for BACK_CYCLES, then → FOLLOW. The obstacle flag is ignored until exit.
- mode is registered and equals the state/decode one cycle after the decision. There is no combinational path from inputs to mode.
- Counters are 32 bits wide and saturate; they never wrap. Each clears on entry to its state.
- enable dropping mid-BACKOFF or mid-HALT aborts to IDLE with mode=000 next cycle; counters clear.
- distance_valid during reset is ignored.

Optional Feature:
- Macro: NAV_DIST_WATCHDOG_EN.
- Defined:
  - A counter clears on every distance_valid.
  - If it reaches WDT_CYCLES, obstacle is forced to 1 (fail-safe stop) until the next distance_valid re-evaluates it.
  - The counter clears on rst.
- Undefined: no watchdog logic. obstacle depends only on distance samples; WDT_CYCLES is unused.

Test Plan (bench parameters: DEBOUNCE=4, LOST_CYCLES=20, HALT_CYCLES=10, BACK_CYCLES=16, STOP_CM=20, HYST_CM=5, WDT_CYCLES=100):
1. rst=1 for 3 cycles, then enable=1, track=010, no distance → mode=000 until about 7 cycles after track is applied, then 011.
2. Line following, track=110, then 100, then 011, each held 10 cycles → mode 001, 001, 010 in sequence. A track=110 glitch lasting 3 cycles inside steady 010 → mode stays 011.
3. Line loss after 001, track=000 → mode=001 for 20 cycles, then 000 (GIVEUP). track=010 then → mode=011 after debounce.
4. Obstacle with distance_valid strobes:
   - distance=19 → obstacle=1, mode=000 for 10 cycles, then 100 for 16 cycles, then FOLLOW.
   - distance=20 → no halt.
   - After being set, distance=24 keeps obstacle=1; distance=25 clears it.
5. enable=0 pulsed mid-BACKOFF → mode=000 next cycle. enable=1 with track=010 → 011, no resumed back-off.
6. With NAV_DIST_WATCHDOG_EN defined, no distance_valid for 100 cycles → obstacle=1 and HALT. distance_valid with distance=100 → obstacle=0.
